// File: rtl/gpu_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_frame_pkg: frame format constants and types shared by the       |
// | frame loader and the scheduler.                      Revision: 1.0  |
// +----------------------------------------------------------------------+
package gpu_frame_pkg;

  localparam int WORD_W     = 64;
  localparam int CNT_W      = 6;
  localparam int BANK_DEPTH = 2 ** CNT_W;
  localparam int NUM_CORES  = 16;

  localparam int FENCE_HI = 7;
  localparam int FENCE_LO = 6;
  localparam int IFNUM_HI = 5;
  localparam int IFNUM_LO = 0;

  typedef struct packed {
    logic [1:0]       fence;
    logic [CNT_W-1:0] if_num;
  } frame_hdr_t;

  typedef enum logic [1:0] {
    W_HDR  = 2'd0,
    W_BODY = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  // Only the low byte of a header word carries meaning.
  function automatic frame_hdr_t decode_hdr(input logic [FENCE_HI:IFNUM_LO] bits);
    frame_hdr_t h;
    h.fence  = bits[FENCE_HI:FENCE_LO];
    h.if_num = bits[IFNUM_HI:IFNUM_LO];
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_loader_if: instruction stream in, presented frame out.        |
// |                                                      Revision: 1.0  |
// +----------------------------------------------------------------------+
interface frame_loader_if;

  logic                             in_valid;
  logic                             in_ready;
  logic [gpu_frame_pkg::WORD_W-1:0] in_data;
  logic                             in_last;

  logic                             frame_valid;
  logic [1:0]                       frame_fence;
  logic [gpu_frame_pkg::CNT_W-1:0]  frame_if_num;
  logic [gpu_frame_pkg::CNT_W-1:0]  rd_addr;
  logic [gpu_frame_pkg::WORD_W-1:0] rd_data;
  logic                             frame_release;

  modport master (
    output in_valid, in_data, in_last, rd_addr, frame_release,
    input  in_ready, frame_valid, frame_fence, frame_if_num, rd_data
  );

  modport slave (
    input  in_valid, in_data, in_last, rd_addr, frame_release,
    output in_ready, frame_valid, frame_fence, frame_if_num, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_bank_ram: one frame of instruction storage, single write port |
// | and registered read port.                            Revision: 1.0  |
// +----------------------------------------------------------------------+
module frame_bank_ram
  import gpu_frame_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [BANK_DEPTH];
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // The storage array itself is never reset; only the output register is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_loader: assembles header+body frames into two ping-pong banks |
// | and presents them in arrival order.                  Revision: 1.0  |
// +----------------------------------------------------------------------+
module frame_loader
  import gpu_frame_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  frame_loader_if.slave        bus,
  output logic                 err_len,
  output logic [ERR_CNT_W-1:0] err_count
);

  wr_state_e              state_q, state_d;
  logic [CNT_W-1:0]       wi_q, wi_d;
  frame_hdr_t             cur_hdr_q, cur_hdr_d;
  frame_hdr_t [1:0]       hdr_q, hdr_d;
  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   rel_pend_q, rel_pend_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   alive_q, alive_d;
  logic                   err_len_q, err_len_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  frame_hdr_t             in_hdr;
  frame_hdr_t             done_hdr;
  logic [CNT_W-1:0]       last_idx;
  logic                   in_ready_w;
  logic                   xfer;
  logic                   frame_done;
  logic                   len_err;
  logic                   body_we;
  logic                   release_fire;
  logic [WORD_W-1:0]      bank_rdata [2];

  assign in_hdr   = decode_hdr(bus.in_data[FENCE_HI:IFNUM_LO]);
  assign last_idx = cur_hdr_q.if_num - CNT_W'(1);

  // alive_q keeps in_ready low until the first clock after reset release.
  assign in_ready_w   = alive_q && ((state_q == W_DROP) || !full_q[wr_bank_q]);
  assign xfer         = bus.in_valid && in_ready_w;
  assign release_fire = bus.frame_release && full_q[rd_bank_q];

  // Write-side FSM: header decode, body capture, and drop-until-last.
  always_comb begin
    state_d    = state_q;
    wi_d       = wi_q;
    cur_hdr_d  = cur_hdr_q;
    done_hdr   = cur_hdr_q;
    frame_done = 1'b0;
    len_err    = 1'b0;
    body_we    = 1'b0;
    case (state_q)
      W_HDR: begin
        if (xfer) begin
          cur_hdr_d = in_hdr;
          done_hdr  = in_hdr;
          wi_d      = '0;
          if (in_hdr.if_num == '0) begin
            if (bus.in_last) begin
              frame_done = 1'b1;
            end else begin
              len_err = 1'b1;
              state_d = W_DROP;
            end
          end else if (bus.in_last) begin
            len_err = 1'b1;
          end else begin
            state_d = W_BODY;
          end
        end
      end
      W_BODY: begin
        if (xfer) begin
          body_we = 1'b1;
          wi_d    = wi_q + CNT_W'(1);
          if (wi_q == last_idx) begin
            if (bus.in_last) begin
              frame_done = 1'b1;
              state_d    = W_HDR;
            end else begin
              len_err = 1'b1;
              state_d = W_DROP;
            end
          end else if (bus.in_last) begin
            len_err = 1'b1;
            state_d = W_HDR;
          end
        end
      end
      W_DROP: begin
        if (xfer && bus.in_last) begin
          state_d = W_HDR;
        end
      end
      default: begin
        state_d = W_HDR;
      end
    endcase
  end

  // Bank bookkeeping. rd_bank advances one cycle after the release so the
  // scheduler always sees a gap between consecutive frames.
  always_comb begin
    full_d     = full_q;
    hdr_d      = hdr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rel_pend_d = 1'b0;
    rd_sel_d   = rd_bank_q;
    alive_d    = 1'b1;
    err_len_d  = len_err;
    err_cnt_d  = err_cnt_q;
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      hdr_d[wr_bank_q]  = done_hdr;
      wr_bank_d         = ~wr_bank_q;
    end
    if (release_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rel_pend_d        = 1'b1;
    end
    if (rel_pend_q) begin
      rd_bank_d = ~rd_bank_q;
    end
    if (len_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= W_HDR;
      wi_q       <= '0;
      cur_hdr_q  <= '0;
      hdr_q      <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rel_pend_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      alive_q    <= 1'b0;
      err_len_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wi_q       <= wi_d;
      cur_hdr_q  <= cur_hdr_d;
      hdr_q      <= hdr_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rel_pend_q <= rel_pend_d;
      rd_sel_q   <= rd_sel_d;
      alive_q    <= alive_d;
      err_len_q  <= err_len_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank_ram u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (body_we && (wr_bank_q == 1'(b))),
      .wr_addr (wi_q),
      .wr_data (bus.in_data),
      .rd_addr (bus.rd_addr),
      .rd_data (bank_rdata[b])
    );
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.frame_valid  = full_q[rd_bank_q];
  assign bus.frame_fence  = full_q[rd_bank_q] ? hdr_q[rd_bank_q].fence  : 2'b00;
  assign bus.frame_if_num = full_q[rd_bank_q] ? hdr_q[rd_bank_q].if_num : '0;
  // Mux on the bank registered alongside the RAM read so data and select align.
  assign bus.rd_data      = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign err_len          = err_len_q;
  assign err_count        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_loader: randomized self-checking bench with a frame-queue  |
// | reference model.                                     Revision: 1.0  |
// +----------------------------------------------------------------------+
module tb_frame_loader;
  import gpu_frame_pkg::*;

  typedef struct {
    logic [1:0]        fence;
    int                n;
    logic [WORD_W-1:0] w [64];
  } frm_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       err_len;
  logic [7:0] err_count;

  frame_loader_if bus ();

  frame_loader #(.ERR_CNT_W(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_len   (err_len),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  int   err_total = 0;
  int   err_pulses = 0;
  int   stalls = 0;
  bit   prod_done = 1'b0;
  frm_t exp_q [$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_pulses <= 0;
    else if (err_len) err_pulses <= err_pulses + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [WORD_W-1:0] d, input logic last);
    int   t;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 500) begin
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(negedge clock);
      t++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_word timeout: in_ready got 0 required 1");
    end
  endtask

  // Model: a stream is a good frame exactly when the body length equals if_num.
  task automatic send_stream(input logic [1:0] fence, input int ifn, input int nw,
                             input bit rel_last);
    frm_t              f;
    logic [WORD_W-1:0] h;
    h = {$urandom, $urandom};
    h[7:0] = {fence, 6'(ifn)};
    f.fence = fence;
    f.n     = ifn;
    for (int i = 0; i < 64; i++) f.w[i] = {$urandom, $urandom};
    if (nw == ifn) exp_q.push_back(f);
    else err_total++;
    if (rel_last && nw == 0) bus.frame_release = 1'b1;
    send_word(h, nw == 0);
    for (int i = 0; i < nw; i++) begin
      if (rel_last && i == nw - 1) bus.frame_release = 1'b1;
      send_word(f.w[i], i == nw - 1);
    end
    bus.frame_release = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_frame(input string nm);
    frm_t f;
    int   t;
    t = 0;
    while (bus.frame_valid !== 1'b1 && t < 300) begin
      @(negedge clock);
      t++;
    end
    tests++;
    if (bus.frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_valid: got %b required 1", nm, bus.frame_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected frame: got if_num %0d required none", nm, bus.frame_if_num);
      return;
    end
    f = exp_q.pop_front();
    tests++;
    if (bus.frame_fence !== f.fence || bus.frame_if_num !== 6'(f.n)) begin
      fails++;
      $display("FAIL %s header: got fence %0d if_num %0d required fence %0d if_num %0d",
               nm, bus.frame_fence, bus.frame_if_num, f.fence, f.n);
    end
    for (int i = 0; i < f.n; i++) begin
      bus.rd_addr = 6'(i);
      @(negedge clock);
      tests++;
      if (bus.rd_data !== f.w[i]) begin
        fails++;
        $display("FAIL %s rd_data[%0d]: got %h required %h", nm, i, bus.rd_data, f.w[i]);
      end
    end
  endtask

  task automatic release_frame(input string nm);
    bus.frame_release = 1'b1;
    @(negedge clock);
    bus.frame_release = 1'b0;
    tests++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s idle after release: frame_valid got %b required 0", nm, bus.frame_valid);
    end
  endtask

  task automatic check_err(input string nm);
    int sat;
    @(negedge clock);
    @(negedge clock);
    sat = (err_total > 255) ? 255 : err_total;
    tests++;
    if (err_count !== 8'(sat)) begin
      fails++;
      $display("FAIL %s err_count: got %0d required %0d", nm, err_count, sat);
    end
    tests++;
    if (err_pulses !== err_total) begin
      fails++;
      $display("FAIL %s err_len pulses: got %0d required %0d", nm, err_pulses, err_total);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b0 || bus.frame_fence !== 2'b00 ||
        bus.frame_if_num !== 6'd0 || bus.rd_data !== 64'd0 || err_len !== 1'b0 ||
        err_count !== 8'd0) begin
      fails++;
      $display("FAIL %s outputs: got rdy %b fv %b fence %0d ifn %0d rd %h el %b ec %0d required all 0",
               nm, bus.in_ready, bus.frame_valid, bus.frame_fence, bus.frame_if_num,
               bus.rd_data, err_len, err_count);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset in_ready before first clock: got %b required 0", bus.in_ready);
    end
    @(negedge clock);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset in_ready after first clock: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    stalls = 0;
    send_stream(2'd2, 3, 3, 1'b0);
    tests++;
    if (bus.frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic frame_valid latency: got %b required 1", bus.frame_valid);
    end
    tests++;
    if (stalls != 0) begin
      fails++;
      $display("FAIL basic throughput stalls: got %0d required 0", stalls);
    end
    check_frame("basic");
    release_frame("basic");
  endtask

  task automatic test_header_only();
    send_stream(2'd1, 0, 0, 1'b0);
    check_frame("hdr_only");
    check_err("hdr_only");
    release_frame("hdr_only");
  endtask

  task automatic test_back_to_back();
    send_stream(2'($urandom), 4, 4, 1'b0);
    send_stream(2'($urandom), 4, 4, 1'b0);
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b in_ready with both banks full: got %b required 0", bus.in_ready);
    end
    fork
      send_stream(2'($urandom), 4, 4, 1'b0);
      begin
        repeat (5) @(negedge clock);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.in_valid !== 1'b1) begin
          fails++;
          $display("FAIL b2b header stall: got in_ready %b required 0", bus.in_ready);
        end
        check_frame("b2b_f1");
        release_frame("b2b_f1");
        check_frame("b2b_f2");
        release_frame("b2b_f2");
        check_frame("b2b_f3");
        release_frame("b2b_f3");
      end
    join
  endtask

  task automatic test_len_errors();
    send_stream(2'd0, 5, 3, 1'b0);
    check_err("len_short");
    tests++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL len_short frame_valid: got %b required 0", bus.frame_valid);
    end
    send_stream(2'd0, 2, 4, 1'b0);
    check_err("len_long");
    send_stream(2'd3, 6, 6, 1'b0);
    check_frame("len_recover");
    release_frame("len_recover");
  endtask

  task automatic test_same_cycle();
    send_stream(2'd1, 2, 2, 1'b0);
    check_frame("same_a");
    send_stream(2'd2, 3, 3, 1'b1);
    tests++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL same idle cycle: frame_valid got %b required 0", bus.frame_valid);
    end
    @(negedge clock);
    tests++;
    if (bus.frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL same next frame: frame_valid got %b required 1", bus.frame_valid);
    end
    check_frame("same_b");
    release_frame("same_b");
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) send_stream(2'd0, 1, 0, 1'b0);
    check_err("err_sat");
  endtask

  task automatic test_random();
    prod_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          int ifn, nw;
          ifn = $urandom_range(0, 8);
          nw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : ifn;
          send_stream(2'($urandom), ifn, nw, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done || exp_q.size() > 0) begin
          if (exp_q.size() > 0) begin
            check_frame("rand");
            repeat ($urandom_range(0, 4)) @(negedge clock);
            release_frame("rand");
          end else begin
            @(negedge clock);
          end
        end
      end
    join
    check_err("rand");
  endtask

  task automatic test_reset_mid();
    send_stream(2'd2, 3, 3, 1'b0);
    send_word({$urandom, $urandom, 8'h05}, 1'b0);
    send_word({$urandom, $urandom}, 1'b0);
    send_word({$urandom, $urandom}, 1'b0);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    err_total = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset in_ready: got %b required 1", bus.in_ready);
    end
    send_stream(2'd1, 1, 1, 1'b0);
    check_frame("mid_reset_new");
    release_frame("mid_reset_new");
    check_err("mid_reset");
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_last       = 1'b0;
    bus.rd_addr       = '0;
    bus.frame_release = 1'b0;
    test_reset();
    test_basic();
    test_header_only();
    test_back_to_back();
    test_len_errors();
    test_same_cycle();
    test_random();
    test_err_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream neighbour of the scheduler: receives a stream of 64-bit instruction words and assembles frames.
- Frame format: one control-flow header word, then if_num instruction words.
- Holds up to two complete frames in ping-pong banks and presents one at a time to the scheduler, with header fields pre-decoded and a random-access read port.
- Catches length mismatches between the header count and the stream's last marker.

Parameters:
- WORD_W, 64, instruction/header word width.
- CNT_W, 6, header instruction-count width; bank depth is 2**CNT_W words.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  WORD_W  header or instruction word.
- in_last  in  1  marks final word of a frame.
- frame_valid  out  1  a complete frame is presented.
- frame_fence  out  2  header bits [7:6] of the presented frame.
- frame_if_num  out  CNT_W  header bits [5:0]; instruction count.
- rd_addr  in  CNT_W  instruction index within the presented frame.
- rd_data  out  WORD_W  instruction at rd_addr, 1-cycle latency.
- frame_release  in  1  scheduler done with the presented frame (1-cycle pulse).
- err_len  out  1  1-cycle pulse on length mismatch.
- err_count  out  ERR_CNT_W  saturating count of err_len events.

Behaviour:
- Reset (async assert, sync deassert):
  - in_ready=0 during reset; becomes 1 on the first clock after deassertion.
  - frame_valid=0, frame_fence=0, frame_if_num=0, rd_data=0, err_len=0, err_count=0.
  - Both banks empty; wr_bank=rd_bank=0.
  - Reset mid-frame discards all partial and complete frames.
- Transfer: a word moves on a cycle where in_valid && in_ready.
- Write FSM, state W_HDR:
  - Captures fence=[7:6] and if_num=[5:0]; bits [63:8] are ignored.
  - Clears word index wi.
  - if_num==0 && in_last: frame complete at this cycle; stays in W_HDR.
  - if_num==0 && !in_last: err_len; goes to W_DROP.
  - if_num>0 && in_last: err_len, frame discarded; stays in W_HDR.
  - Otherwise goes to W_BODY.
- Write FSM, state W_BODY:
  - Writes word to bank[wr_bank][wi]; wi increments.
  - On word wi==if_num-1: in_last=1 completes the frame and goes to W_HDR; in_last=0 raises err_len, discards the frame and goes to W_DROP.
  - in_last=1 on any earlier word: err_len, discard, go to W_HDR.
- Write FSM, state W_DROP:
  - in_ready=1; words are consumed and discarded.
  - in_last returns to W_HDR.
- Frame completion:
  - Sets full[wr_bank] and stores the header into that bank's header register.
  - wr_bank toggles.
- in_ready:
  - In W_DROP: 1.
  - Otherwise: !full[wr_bank].
  - A header is not accepted while the target bank is still full.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_fence and frame_if_num come from rd_bank's header register; they are 0 when frame_valid=0.
  - rd_data is registered from bank[rd_bank][rd_addr] one cycle after rd_addr. Its value is don't-care for rd_addr>=if_num and when frame_valid=0.
- frame_release while frame_valid:
  - Clears full[rd_bank] and toggles rd_bank the next cycle.
  - The next frame, if present, is valid the cycle after that, so there is one idle cycle between frames.
- frame_release while frame_valid=0 is ignored.
- Simultaneous events:
  - Completion into one bank and release of the other in the same cycle: both take effect.
  - Completion into a bank and its release cannot occur in the same cycle, because in_ready blocks writes into a full bank.
- Ordering: frames are presented strictly in arrival order.
- Errors:
  - err_len is a single-cycle pulse per mismatch.
  - err_count saturates at all-ones.
  - A discarded frame never sets full; wr_bank does not toggle.
- Throughput: one word per cycle sustained while a bank is free.

Decomposition:
- Shared package gpu_frame_pkg:
  - WORD_W, CNT_W.
  - Header field positions: FENCE_HI=7, FENCE_LO=6, IFNUM_HI=5, IFNUM_LO=0.
  - NUM_CORES=16.
  - Typedef frame_hdr_t {fence[1:0], if_num[CNT_W-1:0]}.
  - The scheduler imports the same package.
- One sub-module: frame_bank_ram, a 2**CNT_W × WORD_W storage with one write port and one registered read port. It is instantiated twice; the read mux selects by rd_bank.

Test Plan:
1. Header fence=2, if_num=3, then words A,B,C with last on C:
   - frame_valid rises the cycle after C is accepted; fence=2, if_num=3.
   - rd_addr=0,1,2 returns A,B,C each one cycle later.
2. Header-only frame if_num=0 with in_last=1: frame_valid=1, if_num=0, no err_len.
3. Three back-to-back 4-instruction frames, no release:
   - in_ready drops after frame 2 completes; frame 3's header stalls.
   - Release frame 1: frame 2 is presented; frame 3 loads into the freed bank in order.
4. Length errors:
   - Header if_num=5 with last on the 3rd instruction: err_len pulse, err_count=1, no frame_valid; the next valid frame loads normally.
   - Header if_num=2 with no last on the 2nd instruction: W_DROP consumes until last, err_count=2.
5. Same-cycle events: a frame completes into bank 1 on the cycle bank 0 is released; both banks are handled correctly and frame_valid is continuous apart from the one idle cycle.
6. Reset mid-body (after 2 of 5 words), with one full frame buffered:
   - All outputs return to reset values; frame_valid=0.
   - After reset a new 1-instruction frame loads into bank 0.
